ifetch_unit: RTL and testbench

//  Fetch stage consumer of the PC register: takes pc_i each cycle, issues in-order requests to

---
 rtl/riscv_pkg.sv | 18 +
 rtl/ifetch_fifo.sv | 74 +++++++
 rtl/ifetch_unit.sv | 136 +++++++++++++
 tb/tb_ifetch_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: instruction word, NOP encoding and the buffered {instr, pc} pair.
// No logic, no latency.
// Nothing here applies or responds to backpressure.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] instr_t;

   // addi x0, x0, 0
   localparam instr_t NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      instr_t            instr;
      logic [XLEN-1:0]   pc;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of 2 so the pointers wrap for free.
// Latency: a push is visible at pop_dat the cycle after it is written.
// Backpressure: push is dropped when full unless a pop happens the same cycle; pop on empty is ignored.
module ifetch_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   input  logic             flush,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign count   = cnt_q;
   assign pop_dat = mem_q[rptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wptr_q] = push_dat;
            wptr_d        = wptr_q + 1'b1;
         end
         if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: issues in-order imem requests from pc_i, tags responses with their PC, buffers them for decode.
// Latency: accept -> instr_valid_o >= 2 cycles; with IFETCH_BYPASS_EN a response can reach decode the same cycle.
// Backpressure: credit of DEPTH (in flight + buffered); stall_F_o holds the PC register when no request is accepted.
module ifetch_unit #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_i,
   output logic            stall_F_o,
   input  logic            flush_i,
   output logic            imem_req_valid_o,
   output logic [XLEN-1:0] imem_req_addr_o,
   input  logic            imem_req_ready_i,
   input  logic            imem_rsp_valid_i,
   input  logic [XLEN-1:0] imem_rsp_data_i,
   output logic            instr_valid_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            instr_ready_i
);

   import riscv_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   drop_q, drop_d;

   logic            credit_ok, accept;
   logic            rsp_ok, rsp_drop, rsp_keep, byp_vld;

   logic [XLEN-1:0] tag_pc;
   logic [CW-1:0]   tag_cnt;
   logic            tag_empty, tag_full;

   fetch_entry_t    buf_in, buf_head;
   logic            buf_push, buf_pop;
   logic [CW-1:0]   buf_cnt;
   logic            buf_empty, buf_full;

   always_comb begin
      credit_ok = ((CW+1)'(inflight_q) + (CW+1)'(buf_cnt)) < (CW+1)'(DEPTH);
      imem_req_valid_o = credit_ok & ~flush_i & ~rst;
      imem_req_addr_o  = pc_i;
      accept           = imem_req_valid_o & imem_req_ready_i;
      // A flush must let the PC register load the redirect target.
      stall_F_o        = rst | (~flush_i & ~accept);

      rsp_ok   = imem_rsp_valid_i & (inflight_q != '0) & ~rst;
      rsp_drop = rsp_ok & (flush_i | (drop_q != '0));
      rsp_keep = rsp_ok & ~rsp_drop;
`ifdef IFETCH_BYPASS_EN
      byp_vld  = rsp_keep & buf_empty;
`else
      byp_vld  = 1'b0;
`endif
      buf_in.instr = imem_rsp_data_i;
      buf_in.pc    = tag_pc;
      buf_push     = rsp_keep & ~(byp_vld & instr_ready_i);
      buf_pop      = ~buf_empty & instr_ready_i & ~rst;

      instr_valid_o = ~rst & (~buf_empty | byp_vld);
      instr_o       = NOP_INSTR;
      instr_pc_o    = '0;
      if (~rst & ~buf_empty) begin
         instr_o    = buf_head.instr;
         instr_pc_o = buf_head.pc;
      end else if (byp_vld) begin
         instr_o    = imem_rsp_data_i;
         instr_pc_o = tag_pc;
      end

      inflight_d = inflight_q + CW'(accept) - CW'(rsp_ok);
      drop_d     = drop_q;
      // Everything still outstanding after a flush edge belongs to the old path.
      if (flush_i) begin
         drop_d = inflight_q - CW'(rsp_ok);
      end else if (rsp_drop) begin
         drop_d = drop_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   ifetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (accept),
      .push_dat (pc_i),
      .pop      (rsp_ok),
      .pop_dat  (tag_pc),
      .flush    (1'b0),
      .count    (tag_cnt),
      .empty    (tag_empty),
      .full     (tag_full)
   );

   ifetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_instr_buf (
      .clk      (clk),
      .rst      (rst),
      .push     (buf_push),
      .push_dat (buf_in),
      .pop      (buf_pop),
      .pop_dat  (buf_head),
      .flush    (flush_i),
      .count    (buf_cnt),
      .empty    (buf_empty),
      .full     (buf_full)
   );

   a_rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid_i |-> (inflight_q != '0));
   a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (rst)
      (tag_cnt == inflight_q) && (tag_empty == (inflight_q == '0)));
   a_no_tag_overflow: assert property (@(posedge clk) disable iff (rst)
      !(tag_full && accept));
   a_no_buf_overflow: assert property (@(posedge clk) disable iff (rst)
      !(buf_full && buf_push && !buf_pop));

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed cycle table, bypass-sensitive sequence, then randomized run vs a queue model.
// Works with or without IFETCH_BYPASS_EN.
module tb_ifetch_unit;
   import riscv_pkg::*;

   localparam int DEPTH = 2;
`ifdef IFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        stall_F_o;
   logic        flush_i;
   logic        imem_req_valid_o;
   logic [31:0] imem_req_addr_o;
   logic        imem_req_ready_i;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;

   always #5 clk = ~clk;

   ifetch_unit #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .pc_i             (pc_i),
      .stall_F_o        (stall_F_o),
      .flush_i          (flush_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .instr_valid_o    (instr_valid_o),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o),
      .instr_ready_i    (instr_ready_i)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Instruction memory contents as a function of address.
   function automatic logic [31:0] idat(input logic [31:0] pc);
      return (pc * 32'd7) ^ 32'hA5A5_0F0F;
   endfunction

   task automatic drive(input logic r, input logic [31:0] pc, input logic rq, input logic rv,
                        input logic [31:0] rdat, input logic ir, input logic fl);
      rst = r; pc_i = pc; imem_req_ready_i = rq; imem_rsp_valid_i = rv;
      imem_rsp_data_i = rdat; instr_ready_i = ir; flush_i = fl;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        req_rdy;
      logic        rsp_vld;
      logic [31:0] rsp_pc;
      logic        instr_rdy;
      logic        flush;
      logic        e_req;
      logic        e_stall;
      logic        e_vld;
      logic [31:0] e_pc;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic [31:0] pc, input logic rq, input logic rv,
                               input logic [31:0] rpc, input logic ir, input logic fl,
                               input logic er, input logic es, input logic ev, input logic [31:0] epc);
      vec_t v;
      v.rst = r; v.pc = pc; v.req_rdy = rq; v.rsp_vld = rv; v.rsp_pc = rpc;
      v.instr_rdy = ir; v.flush = fl; v.e_req = er; v.e_stall = es; v.e_vld = ev; v.e_pc = epc;
      return v;
   endfunction

   vec_t tbl [27];

   typedef struct {
      logic [31:0] pc;
      bit          killed;
   } tag_t;

   tag_t        tagq [$];
   logic [31:0] bufq [$];

   initial begin
      logic [31:0] pc_r;
      logic        kept, byp, e_vld, e_req, e_stall;
      logic [31:0] e_pc, e_ins;
      int          delivered;
      tag_t        t;

      //            rst pc      rq rv rsp_pc  ir fl   req st vld pc
      tbl[0]  = mk(1, 32'h000, 0, 0, 32'h000, 0, 0,   0, 1, 0, 32'h000);
      tbl[1]  = mk(1, 32'h000, 0, 0, 32'h000, 0, 0,   0, 1, 0, 32'h000);
      tbl[2]  = mk(0, 32'h000, 1, 0, 32'h000, 1, 0,   1, 0, 0, 32'h000);
      tbl[3]  = mk(0, 32'h004, 1, 1, 32'h000, 1, 0,   1, 0, 0, 32'h000);
      tbl[4]  = mk(0, 32'h008, 1, 1, 32'h004, 1, 0,   0, 1, 1, 32'h000);
      tbl[5]  = mk(0, 32'h008, 1, 0, 32'h000, 1, 0,   1, 0, 1, 32'h004);
      tbl[6]  = mk(0, 32'h00C, 1, 1, 32'h008, 1, 0,   1, 0, 0, 32'h000);
      tbl[7]  = mk(0, 32'h010, 1, 1, 32'h00C, 1, 0,   0, 1, 1, 32'h008);
      tbl[8]  = mk(0, 32'h010, 1, 0, 32'h000, 0, 0,   1, 0, 1, 32'h00C);
      tbl[9]  = mk(0, 32'h014, 1, 1, 32'h010, 0, 0,   0, 1, 1, 32'h00C);
      tbl[10] = mk(0, 32'h014, 1, 0, 32'h000, 0, 0,   0, 1, 1, 32'h00C);
      tbl[11] = mk(0, 32'h014, 1, 0, 32'h000, 1, 0,   0, 1, 1, 32'h00C);
      tbl[12] = mk(0, 32'h014, 1, 0, 32'h000, 1, 0,   1, 0, 1, 32'h010);
      tbl[13] = mk(0, 32'h018, 0, 1, 32'h014, 1, 0,   1, 1, 0, 32'h000);
      tbl[14] = mk(0, 32'h018, 0, 0, 32'h000, 1, 0,   1, 1, 1, 32'h014);
      tbl[15] = mk(0, 32'h018, 1, 0, 32'h000, 1, 0,   1, 0, 0, 32'h000);
      tbl[16] = mk(0, 32'h01C, 1, 0, 32'h000, 1, 0,   1, 0, 0, 32'h000);
      tbl[17] = mk(0, 32'h020, 1, 0, 32'h000, 1, 1,   0, 0, 0, 32'h000);
      tbl[18] = mk(0, 32'h100, 1, 1, 32'h018, 1, 0,   0, 1, 0, 32'h000);
      tbl[19] = mk(0, 32'h100, 1, 1, 32'h01C, 1, 0,   1, 0, 0, 32'h000);
      tbl[20] = mk(0, 32'h104, 0, 1, 32'h100, 1, 0,   1, 1, 0, 32'h000);
      tbl[21] = mk(0, 32'h104, 0, 0, 32'h000, 1, 0,   1, 1, 1, 32'h100);
      tbl[22] = mk(0, 32'h104, 1, 0, 32'h000, 1, 0,   1, 0, 0, 32'h000);
      tbl[23] = mk(0, 32'h108, 1, 1, 32'h104, 1, 1,   0, 0, 0, 32'h000);
      tbl[24] = mk(0, 32'h200, 1, 0, 32'h000, 1, 0,   1, 0, 0, 32'h000);
      tbl[25] = mk(0, 32'h204, 0, 1, 32'h200, 1, 0,   1, 1, 0, 32'h000);
      tbl[26] = mk(0, 32'h204, 0, 0, 32'h000, 1, 0,   1, 1, 1, 32'h200);

      drive(1, 0, 0, 0, 0, 0, 0);
      #1;

      // Directed table: reset, streaming, back-pressure, flush with two in flight, flush-cycle response.
      // The expected decode-side values assume registered responses.
`ifndef IFETCH_BYPASS_EN
      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].rst, tbl[i].pc, tbl[i].req_rdy, tbl[i].rsp_vld, idat(tbl[i].rsp_pc),
               tbl[i].instr_rdy, tbl[i].flush);
         @(negedge clk);
         chk($sformatf("tbl%0d.req_valid", i), 32'(imem_req_valid_o), 32'(tbl[i].e_req));
         chk($sformatf("tbl%0d.stall_F", i),   32'(stall_F_o),        32'(tbl[i].e_stall));
         chk($sformatf("tbl%0d.instr_valid", i), 32'(instr_valid_o),  32'(tbl[i].e_vld));
         chk($sformatf("tbl%0d.instr", i), instr_o, tbl[i].e_vld ? idat(tbl[i].e_pc) : NOP_INSTR);
         chk($sformatf("tbl%0d.instr_pc", i), instr_pc_o, tbl[i].e_pc);
         next_cycle();
      end
`endif

      // Same-cycle vs next-cycle delivery of a response to an empty buffer.
      drive(1, 0, 0, 0, 0, 0, 0);
      next_cycle();
      next_cycle();
      drive(0, 32'h20, 1, 0, 0, 1, 0);
      @(negedge clk);
      chk("byp.accept", 32'(imem_req_valid_o & ~stall_F_o), 32'd1);
      next_cycle();
      drive(0, 32'h24, 0, 1, 32'h0050_0093, 1, 0);
      @(negedge clk);
      chk("byp.rsp_cycle_valid", 32'(instr_valid_o), 32'(BYP));
      chk("byp.rsp_cycle_pc",    instr_pc_o, BYP ? 32'h20 : 32'h0);
      chk("byp.rsp_cycle_instr", instr_o,    BYP ? 32'h0050_0093 : NOP_INSTR);
      next_cycle();
      drive(0, 32'h24, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("byp.next_cycle_valid", 32'(instr_valid_o), 32'(!BYP));
      chk("byp.next_cycle_pc",    instr_pc_o, BYP ? 32'h0 : 32'h20);
      chk("byp.next_cycle_instr", instr_o,    BYP ? NOP_INSTR : 32'h0050_0093);
      next_cycle();

      // Randomized run against a queue-level model of the fetch pipe.
      drive(1, 0, 0, 0, 0, 0, 0);
      next_cycle();
      next_cycle();
      tagq.delete();
      bufq.delete();
      pc_r      = 32'h1000;
      delivered = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst              = 1'b0;
         pc_i             = pc_r;
         flush_i          = ($urandom_range(0, 19) == 0);
         imem_req_ready_i = ($urandom_range(0, 3) != 0);
         imem_rsp_valid_i = (tagq.size() > 0) && ($urandom_range(0, 2) != 0);
         imem_rsp_data_i  = imem_rsp_valid_i ? idat(tagq[0].pc) : $urandom;
         instr_ready_i    = flush_i ? 1'b0 : ($urandom_range(0, 9) < 7);
         @(negedge clk);

         kept    = imem_rsp_valid_i && !tagq[0].killed && !flush_i;
         byp     = BYP && kept && (bufq.size() == 0);
         e_vld   = (bufq.size() > 0) || byp;
         e_pc    = (bufq.size() > 0) ? bufq[0] : (byp ? tagq[0].pc : 32'h0);
         e_ins   = e_vld ? idat(e_pc) : NOP_INSTR;
         e_req   = ((tagq.size() + bufq.size()) < DEPTH) && !flush_i;
         e_stall = flush_i ? 1'b0 : !(e_req && imem_req_ready_i);

         chk("rnd.req_valid",   32'(imem_req_valid_o), 32'(e_req));
         chk("rnd.stall_F",     32'(stall_F_o),        32'(e_stall));
         chk("rnd.instr_valid", 32'(instr_valid_o),    32'(e_vld));
         chk("rnd.instr",       instr_o,    e_ins);
         chk("rnd.instr_pc",    instr_pc_o, e_pc);
         if (e_req) chk("rnd.req_addr", imem_req_addr_o, pc_r);

         if (e_vld && instr_ready_i) delivered++;
         if (imem_rsp_valid_i) begin
            t = tagq.pop_front();
            if (kept && !(byp && instr_ready_i)) bufq.push_back(t.pc);
         end
         if (e_vld && instr_ready_i && !byp) void'(bufq.pop_front());
         if (flush_i) begin
            bufq.delete();
            foreach (tagq[k]) tagq[k].killed = 1'b1;
         end
         if (e_req && imem_req_ready_i) tagq.push_back('{pc: pc_r, killed: 1'b0});
         if (flush_i)       pc_r = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
         else if (!e_stall) pc_r = pc_r + 32'd4;
         next_cycle();
      end
      chk("rnd.enough_deliveries", 32'(delivered > 300), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
